// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes, register IDs,
// the sequencer state encoding and small instruction-class helpers.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Architectural status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Register IDs with fixed meaning
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPDATE  = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  // True for instructions that touch data memory in the MEMORY stage
  function automatic logic is_mem_op(input logic [3:0] icode);
    logic r;
    case (icode)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
      default:                                      r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the memory instructions that store rather than load
  function automatic logic is_mem_write(input logic [3:0] icode);
    logic r;
    case (icode)
      IRMMOVQ, ICALL, IPUSHQ: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Handshake and control bundle between the SEQ sequencer and its datapath:
// fetch results, data-memory handshake, stage enables and register selects.
interface seq_ctrl_if;

  // Fetch results
  logic       instr_valid;
  logic [3:0] icode;
  logic [3:0] ifun;
  logic [3:0] rA;
  logic [3:0] rB;
  logic       imem_error;

  // Execute condition
  logic       Cnd;

  // Data-memory handshake
  logic       dmem_req;
  logic       dmem_wr;
  logic       dmem_ack;
  logic       dmem_error;

  // Stage enables
  logic       fetch_en;
  logic       decode_en;
  logic       exec_en;
  logic       wb_en;
  logic       pc_en;

  // Register-file port selects
  logic [3:0] srcA;
  logic [3:0] srcB;
  logic [3:0] dstE;
  logic [3:0] dstM;

  // Sequencer side
  modport master (
    input  instr_valid, icode, ifun, rA, rB, imem_error, Cnd, dmem_ack, dmem_error,
    output fetch_en, decode_en, exec_en, wb_en, pc_en, dmem_req, dmem_wr,
    output srcA, srcB, dstE, dstM
  );

  // Datapath side
  modport slave (
    output instr_valid, icode, ifun, rA, rB, imem_error, Cnd, dmem_ack, dmem_error,
    input  fetch_en, decode_en, exec_en, wb_en, pc_en, dmem_req, dmem_wr,
    input  srcA, srcB, dstE, dstM
  );

endinterface

// File: rtl/y86_reg_select.sv
// Combinational map from an instruction's icode/rA/rB and its condition
// flag to the four register-file port selects. Shared with the pipelined core.
module y86_reg_select
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       Cnd,
  output logic [3:0] srcA,
  output logic [3:0] srcB,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);

  // Per-icode port selection; anything not listed uses no register
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      IRRMOVQ: begin
        srcA = rA;
        if (Cnd) begin
          dstE = rB;
        end else begin
          dstE = RNONE;
        end
      end
      IIRMOVQ: begin
        dstE = rB;
      end
      IRMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      IMRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      IOPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      ICALL: begin
        srcB = RSP;
        dstE = RSP;
      end
      IRET: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
      end
      IPUSHQ: begin
        srcA = rA;
        srcB = RSP;
        dstE = RSP;
      end
      IPOPQ: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
        dstM = rA;
      end
      default: begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
      end
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle control sequencer for the Y86 SEQ datapath. Walks each
// instruction through FETCH..PCUPDATE, waits on the data-memory handshake,
// drives register selects and tracks architectural status and retire count.
// All outputs are registered from the next-state values so that each one
// lines up exactly with the cycles spent in the corresponding state.
import y86_pkg::*;

module seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  seq_ctrl_if.master       bus,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_r;
  state_t           state_nx;
  logic [3:0]       icode_r;
  logic [3:0]       icode_nx;
  logic [3:0]       ra_r;
  logic [3:0]       ra_nx;
  logic [3:0]       rb_r;
  logic [3:0]       rb_nx;
  logic             cnd_r;
  logic             cnd_nx;
  logic [2:0]       stat_nx;
  logic             cnt_inc_s;
  logic [TMO_W-1:0] tmo_r;

  logic [3:0]       src_a_s;
  logic [3:0]       src_b_s;
  logic [3:0]       dst_e_s;
  logic [3:0]       dst_m_s;
  logic             mem_nx_s;
  logic             wr_nx_s;
  logic             rf_window_s;

  // Selects are computed from the fields as they will be latched next cycle,
  // so the registered copies match the instruction being decoded/executed.
  y86_reg_select u_reg_select (
    .icode (icode_nx),
    .rA    (ra_nx),
    .rB    (rb_nx),
    .Cnd   (cnd_nx),
    .srcA  (src_a_s),
    .srcB  (src_b_s),
    .dstE  (dst_e_s),
    .dstM  (dst_m_s)
  );

  // Next-state, field latching, status and retire decisions
  always_comb begin
    state_nx  = state_r;
    icode_nx  = icode_r;
    ra_nx     = ra_r;
    rb_nx     = rb_r;
    cnd_nx    = cnd_r;
    stat_nx   = stat;
    cnt_inc_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx = S_FETCH;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.instr_valid) begin
          icode_nx = bus.icode;
          ra_nx    = bus.rA;
          rb_nx    = bus.rB;
          // Condition is not known until EXECUTE; start each instruction false
          cnd_nx   = 1'b0;
          if (bus.imem_error) begin
            state_nx = S_HALT;
            stat_nx  = STAT_ADR;
          end else if (bus.icode > IPOPQ) begin
            state_nx = S_HALT;
            stat_nx  = STAT_INS;
          end else if (bus.icode == IHALT) begin
            state_nx  = S_HALT;
            stat_nx   = STAT_HLT;
            cnt_inc_s = 1'b1;
          end else begin
            state_nx = S_DECODE;
          end
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_DECODE: begin
        state_nx = S_EXECUTE;
      end
      S_EXECUTE: begin
        cnd_nx   = bus.Cnd;
        state_nx = S_MEMORY;
      end
      S_MEMORY: begin
        if (is_mem_op(icode_r)) begin
          if (bus.dmem_ack) begin
            if (bus.dmem_error) begin
              state_nx = S_HALT;
              stat_nx  = STAT_ADR;
            end else begin
              state_nx = S_WRITEBACK;
            end
          end else if (tmo_r == TMO_LAST) begin
            state_nx = S_HALT;
            stat_nx  = STAT_ADR;
          end else begin
            state_nx = S_MEMORY;
          end
        end else begin
          state_nx = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        state_nx = S_PCUPDATE;
      end
      S_PCUPDATE: begin
        state_nx  = S_FETCH;
        cnt_inc_s = 1'b1;
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    mem_nx_s    = (state_nx == S_MEMORY) && is_mem_op(icode_nx);
    wr_nx_s     = mem_nx_s && is_mem_write(icode_nx);
    rf_window_s = (state_nx == S_DECODE) || (state_nx == S_EXECUTE) ||
                  (state_nx == S_MEMORY) || (state_nx == S_WRITEBACK);
  end

  // State, latched fields, timeout counter, status and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      icode_r     <= INOP;
      ra_r        <= RNONE;
      rb_r        <= RNONE;
      cnd_r       <= 1'b0;
      tmo_r       <= {TMO_W{1'b0}};
      stat        <= STAT_AOK;
      instr_count <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx;
      icode_r <= icode_nx;
      ra_r    <= ra_nx;
      rb_r    <= rb_nx;
      cnd_r   <= cnd_nx;
      stat    <= stat_nx;
      // Counts cycles spent in MEMORY; any other state clears it for entry
      if (state_r == S_MEMORY) begin
        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end else begin
        tmo_r <= {TMO_W{1'b0}};
      end
      if (cnt_inc_s) begin
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instr_count <= instr_count;
      end
    end
  end

  // Registered stage enables, memory request and register selects
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fetch_en  <= 1'b0;
      bus.decode_en <= 1'b0;
      bus.exec_en   <= 1'b0;
      bus.wb_en     <= 1'b0;
      bus.pc_en     <= 1'b0;
      bus.dmem_req  <= 1'b0;
      bus.dmem_wr   <= 1'b0;
      bus.srcA      <= RNONE;
      bus.srcB      <= RNONE;
      bus.dstE      <= RNONE;
      bus.dstM      <= RNONE;
      busy          <= 1'b0;
    end else begin
      bus.fetch_en  <= (state_nx == S_FETCH);
      bus.decode_en <= (state_nx == S_DECODE);
      bus.exec_en   <= (state_nx == S_EXECUTE);
      bus.wb_en     <= (state_nx == S_WRITEBACK);
      bus.pc_en     <= (state_nx == S_PCUPDATE);
      bus.dmem_req  <= mem_nx_s;
      bus.dmem_wr   <= wr_nx_s;
      busy          <= (state_nx != S_IDLE) && (state_nx != S_HALT);
      if (rf_window_s) begin
        bus.srcA <= src_a_s;
        bus.srcB <= src_b_s;
        bus.dstE <= dst_e_s;
        bus.dstM <= dst_m_s;
      end else begin
        bus.srcA <= RNONE;
        bus.srcB <= RNONE;
        bus.dstE <= RNONE;
        bus.dstM <= RNONE;
      end
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl. For every instruction the bench first
// writes down the expected stage-by-stage timeline from the instruction's
// class and the planned handshake delays, then plays it cycle by cycle,
// comparing enables, memory request, selects, status and retire count.
module tb_seq_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  localparam int SF = 0;
  localparam int SD = 1;
  localparam int SE = 2;
  localparam int SM = 3;
  localparam int SW = 4;
  localparam int SP = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] instr_count;

  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_count = '0;
  logic [2:0]       exp_stat = 3'd1;
  int               plan[$];

  seq_ctrl_if bus();

  seq_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .stat        (stat),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register selects straight from the instruction table: {srcA,srcB,dstE,dstM}
  function automatic logic [15:0] exp_sel(input logic [3:0] ic, input logic [3:0] ra,
                                          input logic [3:0] rb, input bit c);
    logic [3:0] sa, sb, de, dm;
    sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    if ((ic inside {4'h3, 4'h6}) || (ic == 4'h2 && c)) de = rb;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'h4;
    else de = 4'hF;
    dm = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    return {sa, sb, de, dm};
  endfunction

  function automatic logic [7:0] ctrl_obs();
    return {bus.fetch_en, bus.decode_en, bus.exec_en, bus.wb_en, bus.pc_en,
            bus.dmem_req, bus.dmem_wr, busy};
  endfunction

  function automatic logic [15:0] sel_obs();
    return {bus.srcA, bus.srcB, bus.dstE, bus.dstM};
  endfunction

  // Random values on every datapath input; callers override what matters
  task automatic glitch_inputs();
    bus.instr_valid = 1'($urandom);
    bus.icode       = 4'($urandom);
    bus.ifun        = 4'($urandom);
    bus.rA          = 4'($urandom);
    bus.rB          = 4'($urandom);
    bus.imem_error  = 1'($urandom);
    bus.Cnd         = 1'($urandom);
    bus.dmem_ack    = 1'($urandom);
    bus.dmem_error  = 1'($urandom);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, 64'(ctrl_obs()), 64'h0);
    chk({tag, "_sel"}, 64'(sel_obs()), 64'hFFFF);
    chk({tag, "_stat"}, 64'(stat), 64'd1);
    chk({tag, "_count"}, 64'(instr_count), 64'd0);
  endtask

  task automatic do_reset();
    glitch_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = '0;
    exp_stat  = 3'd1;
    check_reset("reset");
    glitch_inputs();
    @(posedge clk); #1;
    chk("idle_ctrl", 64'(ctrl_obs()), 64'h0);
  endtask

  task automatic start_run();
    glitch_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      glitch_inputs();
      start = 1'($urandom);
      @(posedge clk); #1;
      chk("halt_ctrl", 64'(ctrl_obs()), 64'h0);
      chk("halt_stat", 64'(stat), 64'(exp_stat));
      chk("halt_count", 64'(instr_count), 64'(exp_count));
    end
    start = 1'b0;
  endtask

  // Plays one instruction starting in FETCH. Returns halted=1 if the
  // instruction stops the machine (or a mid-MEMORY reset was applied).
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                           input int fw, input int aw, input bit ierr, input bit derr,
                           input bit tmo, input bit cnd, input bit rst_mid,
                           output bit halted);
    bit mem, wr, stops;
    logic [2:0] end_stat;
    int n, m_end, s;
    logic [15:0] mask;
    logic [7:0] exp_ctrl;
    mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    wr  = ic inside {4'h4, 4'h8, 4'hA};
    n   = !mem ? 1 : (tmo ? MEM_TIMEOUT : aw + 1);
    m_end = fw + 2 + n;
    stops = 1'b0;
    end_stat = 3'd1;
    plan.delete();
    for (int i = 0; i <= fw; i++) plan.push_back(SF);
    if (ierr) begin
      stops = 1'b1; end_stat = 3'd3;
    end else if (ic > 4'hB) begin
      stops = 1'b1; end_stat = 3'd4;
    end else if (ic == 4'h0) begin
      stops = 1'b1; end_stat = 3'd2;
    end else begin
      plan.push_back(SD);
      plan.push_back(SE);
      for (int i = 0; i < n; i++) plan.push_back(SM);
      if (mem && (tmo || derr)) begin
        stops = 1'b1; end_stat = 3'd3;
      end else begin
        plan.push_back(SW);
        plan.push_back(SP);
      end
    end

    for (int k = 0; k < plan.size(); k++) begin
      s = plan[k];
      exp_ctrl = {s == SF, s == SD, s == SE, s == SW, s == SP,
                  (s == SM) && mem, (s == SM) && mem && wr, 1'b1};
      chk("ctrl", 64'(ctrl_obs()), 64'(exp_ctrl));
      chk("stat", 64'(stat), 64'(exp_stat));
      chk("count", 64'(instr_count), 64'(exp_count));
      if (s inside {SD, SE, SM, SW}) begin
        mask = (s == SM || s == SW) ? 16'hFFFF : 16'hFF0F;
        chk("sel", 64'(sel_obs() & mask), 64'(exp_sel(ic, ra, rb, cnd) & mask));
      end
      glitch_inputs();
      start = 1'($urandom);
      if (s == SF) begin
        bus.instr_valid = (k == fw);
        if (k == fw) begin
          bus.icode      = ic;
          bus.rA         = ra;
          bus.rB         = rb;
          bus.imem_error = ierr;
        end
      end
      if (s == SE) bus.Cnd = cnd;
      if (s == SM && mem) begin
        bus.dmem_ack   = !tmo && (k == m_end);
        bus.dmem_error = derr;
      end
      if (rst_mid && k == fw + 4) rst = 1'b1;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        start = 1'b0;
        exp_count = '0;
        exp_stat  = 3'd1;
        check_reset("midmem_reset");
        halted = 1'b1;
        return;
      end
    end
    start = 1'b0;
    if (stops) begin
      exp_stat = end_stat;
      if (ic == 4'h0 && !ierr) exp_count = exp_count + 1;
      halt_check(3);
    end else begin
      exp_count = exp_count + 1;
    end
    halted = stops;
  endtask

  logic [3:0] mem_ops [6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  initial begin
    bit h;
    int r;
    logic [3:0] ic;
    glitch_inputs();

    // Reset and the directed cases
    do_reset();
    start_run();
    run_instr(4'h3, 4'hF, 4'h2, 0, 0, 0, 0, 0, 0, 0, h);   // irmovq, 6 cycles
    run_instr(4'hA, 4'h1, 4'hF, 0, 2, 0, 0, 0, 0, 0, h);   // pushq, ack on 3rd cycle
    run_instr(4'h2, 4'h3, 4'h5, 0, 0, 0, 0, 0, 0, 0, h);   // cmov not taken
    run_instr(4'h2, 4'h3, 4'h5, 1, 0, 0, 0, 0, 1, 0, h);   // cmov taken
    run_instr(4'h5, 4'h7, 4'h1, 0, 4, 0, 0, 0, 0, 1, h);   // reset mid-MEMORY
    start_run();
    run_instr(4'hC, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, h);   // invalid icode
    do_reset();
    start_run();
    run_instr(4'h5, 4'h2, 4'h3, 0, 0, 0, 0, 1, 0, 0, h);   // memory timeout
    do_reset();
    start_run();
    run_instr(4'hB, 4'h6, 4'hF, 0, 1, 0, 1, 0, 0, 0, h);   // dmem_error
    do_reset();
    start_run();
    run_instr(4'h6, 4'h1, 4'h2, 1, 0, 1, 0, 0, 0, 0, h);   // imem_error
    do_reset();
    start_run();
    run_instr(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, h);   // nop
    run_instr(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, h);   // halt retires
    do_reset();
    start_run();

    // Randomized instruction stream with occasional terminating faults
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 23);
      ic = 4'($urandom_range(1, 11));
      case (r)
        18: run_instr(4'h0, 4'($urandom), 4'($urandom), $urandom_range(0, 2), 0, 0, 0, 0, 0, 0, h);
        19: run_instr(4'($urandom_range(12, 15)), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 2), 0, 0, 0, 0, 0, 0, h);
        20: run_instr(ic, 4'($urandom), 4'($urandom), $urandom_range(0, 2), 0, 1, 0, 0, 0, 0, h);
        21: run_instr(mem_ops[$urandom_range(0, 5)], 4'($urandom), 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 4), 0, 1, 0, 1'($urandom), 0, h);
        22: run_instr(mem_ops[$urandom_range(0, 5)], 4'($urandom), 4'($urandom),
                      0, 0, 0, 0, 1, 1'($urandom), 0, h);
        default: run_instr(ic, 4'($urandom), 4'($urandom), $urandom_range(0, 3),
                           $urandom_range(0, 5), 0, 0, 0, 1'($urandom), 0, h);
      endcase
      if (h) begin
        do_reset();
        start_run();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
